pipe_hazard_ctrl: RTL



---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipe_hazard_ctrl_mc_timer.sv | 27 ++
 rtl/pipe_hazard_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// Holds the controller FSM states, forwarding select codes and hazard compare helpers.
package pipe_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    MCBUSY = 1'b1
  } pipe_state_t;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // M has priority over W, because it holds the younger result.
  function automatic logic [1:0] fwd_sel(
    input logic       reg_write_m,
    input logic [4:0] rd_m,
    input logic       reg_write_w,
    input logic [4:0] rd_w,
    input logic [4:0] rs
  );
    if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs)) begin
      return FWD_M;
    end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs)) begin
      return FWD_W;
    end
    return FWD_RF;
  endfunction

  function automatic logic load_use(
    input logic       mem_read_e,
    input logic [4:0] rd_e,
    input logic [4:0] rs1_d,
    input logic [4:0] rs2_d
  );
    return mem_read_e && (rd_e != 5'd0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_mc_timer.sv
// Loadable down-counter that tracks the remaining EX occupancy of a multi-cycle op.
// The one_hit flag marks the final cycle of the op.
module mc_timer #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] value,
  output logic         one_hit
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - W'(1);
    end
  end

  assign one_hit = (value == W'(1));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall, flush and forwarding control for the 5-stage RV32 pipeline, including MUL/DIV hold.
// Define PIPE_HAZARD_PERF_EN to add the StallCnt/FlushCnt performance counters.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned MC_LATENCY = 4
`ifdef PIPE_HAZARD_PERF_EN
  ,
  parameter int unsigned CNT_W      = 32
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] Rs1D,
  input  logic [4:0] Rs2D,
  input  logic [4:0] Rs1E,
  input  logic [4:0] Rs2E,
  input  logic [4:0] RdE,
  input  logic       MemReadE,
  input  logic       McStartE,
  input  logic       PCSrcE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic [4:0] RdM,
  input  logic [4:0] RdW,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       FlushM,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       McDoneE
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
`endif
);

  localparam int unsigned CntW = $clog2(MC_LATENCY);

  if ((MC_LATENCY < 2) || (MC_LATENCY > 15)) begin : g_bad_latency
    $error("pipe_hazard_ctrl: MC_LATENCY must be in 2..15");
  end

  pipe_state_t     state_q, state_d;
  logic            cnt_load, cnt_dec, cnt_one;
  logic [CntW-1:0] cnt;

  mc_timer #(
    .W (CntW)
  ) u_mc_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (CntW'(MC_LATENCY - 1)),
    .dec      (cnt_dec),
    .value    (cnt),
    .one_hit  (cnt_one)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushM    = 1'b0;
    McDoneE   = 1'b0;
    ForwardAE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
    ForwardBE = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);

    unique case (state_q)
      RUN: begin
        if (PCSrcE) begin
          FlushD = 1'b1;
          FlushE = 1'b1;
        end else if (McStartE) begin
          StallF   = 1'b1;
          StallD   = 1'b1;
          StallE   = 1'b1;
          FlushM   = 1'b1;
          cnt_load = 1'b1;
          state_d  = MCBUSY;
        end else if (load_use(MemReadE, RdE, Rs1D, Rs2D)) begin
          StallF = 1'b1;
          StallD = 1'b1;
          FlushE = 1'b1;
        end
      end
      MCBUSY: begin
        // Redirects and new hazards wait: EX still owns the multi-cycle op.
        if (cnt_one) begin
          McDoneE = 1'b1;
          state_d = RUN;
        end else if (cnt > CntW'(1)) begin
          StallF  = 1'b1;
          StallD  = 1'b1;
          StallE  = 1'b1;
          FlushM  = 1'b1;
          cnt_dec = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase

    // Everything reads as idle while reset is held, independent of the clock.
    if (reset) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      McDoneE   = 1'b0;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (StallF) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (FlushE) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign StallCnt = reset ? '0 : stall_cnt_q;
  assign FlushCnt = reset ? '0 : flush_cnt_q;
`endif

endmodule
